// File: rtl/hc_seq_pkg.sv
// Shared helpers for the one-hot phase sequencer family: index width sizing
// and a generic one-hot decode used by the decoder sub-module.
package hc_seq_pkg;

  localparam int MAX_N = 256;

  // Width of a binary index able to address n states; never narrower than 1.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_N-1:0] onehot_decode(input logic [31:0] idx);
    logic [MAX_N-1:0] one;
    one = MAX_N'(1);
    return one << idx;
  endfunction

endpackage

// File: rtl/hc_onehot_decode.sv
// Binary index to N-wide one-hot decoder; feeds the sequencer's q register and
// is reusable by other phase logic.
module hc_onehot_decode
  import hc_seq_pkg::*;
#(
  parameter int N = 10,
  parameter int W = idx_width(N)
) (
  input  logic [W-1:0] idx,
  output logic [N-1:0] q
);

  logic [MAX_N-1:0] full;

  assign full = onehot_decode(32'(idx));
  assign q    = full[N-1:0];

  generate
    if (N < MAX_N) begin : g_spare
      // Bits above N are never reachable; fold them so they are not left dangling.
      logic unused_hi;
      assign unused_hi = ^full[MAX_N-1:N];
    end
  endgenerate

endmodule

// File: rtl/hc_onehot_sequencer.sv
// Parametrised one-hot phase sequencer: programmable wrap, up/down, load,
// half-sequence carry (_co) and cascade terminal count (tc).
module hc_onehot_sequencer
  import hc_seq_pkg::*;
#(
  parameter int N = 10,
  parameter int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         mr,
  input  logic         _en,
  input  logic         dir,
  input  logic [W-1:0] last,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [N-1:0] q,
  output logic [W-1:0] idx,
  output logic         _co,
  output logic         tc
);

  localparam logic [W-1:0] LAST_MAX = W'(N - 1);

  logic [W-1:0] last_eff;
  logic [W-1:0] idx_nxt;
  logic [N-1:0] q_nxt;
  logic [W:0]   half;

  assign last_eff = (last > LAST_MAX) ? LAST_MAX : last;

  // Next-state priority: reset > load > count > hold. Out-of-range states
  // (after last is lowered) recover to 0 going up and to last_eff going down.
  always_comb begin
    idx_nxt = idx;
    if (mr) begin
      idx_nxt = '0;
    end else if (load) begin
      idx_nxt = (load_val > last_eff) ? '0 : load_val;
    end else if (!_en) begin
      if (!dir) begin
        idx_nxt = (idx >= last_eff) ? '0 : idx + W'(1);
      end else begin
        idx_nxt = ((idx == '0) || (idx > last_eff)) ? last_eff : idx - W'(1);
      end
    end
  end

  hc_onehot_decode #(
    .N (N),
    .W (W)
  ) u_decode (
    .idx (idx_nxt),
    .q   (q_nxt)
  );

  // q is registered from the decode of idx_nxt so it never lags idx.
  always_ff @(posedge clk) begin
    if (mr) begin
      idx <= '0;
      q   <= N'(1);
    end else begin
      idx <= idx_nxt;
      q   <= q_nxt;
    end
  end

  assign half = ({1'b0, last_eff} + (W+1)'(2)) >> 1;
  assign _co  = mr | ({1'b0, idx} < half);
  assign tc   = !mr && !_en && (dir ? (idx == '0) : (idx >= last_eff));

endmodule
